// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier datapath helpers: the scan-mux
// state encoding and the select-width helper used to size index buses.
package mul_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Index width for n words, never narrower than one bit so N=1 still
    // has a legal select bus.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_scan_if.sv
// Bundle of the scan-mux data, control and status signals. The master side
// drives the words, select and scan controls; the slave side (the mux)
// returns the registered word and its status flags.
interface mux_scan_if #(
    parameter int N = 5,
    parameter int W = 1
);
    localparam int SW = mul_pkg::clog2_min1(N);

    logic [N*W-1:0] d;
    logic [SW-1:0]  s;
    logic           start;
    logic           en;
    logic [W-1:0]   y;
    logic           valid;
    logic           last;
    logic           busy;
    logic [SW-1:0]  idx;

    modport master (
        output d, s, start, en,
        input  y, valid, last, busy, idx
    );

    modport slave (
        input  d, s, start, en,
        output y, valid, last, busy, idx
    );

endinterface

// File: rtl/mux_n.sv
// Combinational N:1 selector of W-bit words. Any select code with no
// matching word (sel >= N) yields zero.
module mux_n
    import mul_pkg::*;
#(
    parameter int N = 5,
    parameter int W = 1
) (
    input  logic [N*W-1:0]              d,
    input  logic [clog2_min1(N)-1:0]    sel,
    output logic [W-1:0]                y
);

    localparam int SW = clog2_min1(N);

    // Zero by default, then pick the word whose index matches the select.
    always_comb begin
        y = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SW'(k)) begin
                y = d[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_scan.sv
// Registered N:1 word multiplexer with a direct-select mode and a scan mode
// that walks every input once, one word per enabled cycle. Feeds operand and
// partial-product selection and the sequential multiplier's bit stream.
// Build option MUX_SCAN_REVERSE_EN: scan runs N-1 down to 0 (MSB first);
// otherwise it runs 0 up to N-1. Direct mode is the same in both builds.
module mux_scan
    import mul_pkg::*;
#(
    parameter int N = 5,
    parameter int W = 1
) (
    input  logic       clk,
    input  logic       reset,
    mux_scan_if.slave  bus
);

    localparam int SW = clog2_min1(N);

`ifdef MUX_SCAN_REVERSE_EN
    localparam logic [SW-1:0] FIRST_IDX = SW'(N - 1);
    localparam logic [SW-1:0] LAST_IDX  = '0;
`else
    localparam logic [SW-1:0] FIRST_IDX = '0;
    localparam logic [SW-1:0] LAST_IDX  = SW'(N - 1);
`endif

    state_t          state;
    logic [SW-1:0]   cnt;
    logic [SW-1:0]   sel;
    logic [W-1:0]    mux_y;

    // The scan counter owns the selector while scanning; otherwise the
    // caller's direct select does.
    assign sel = (state == SCAN) ? cnt : bus.s;

    mux_n #(.N(N), .W(W)) u_mux (
        .d   (bus.d),
        .sel (sel),
        .y   (mux_y)
    );

    // busy comes straight off the state register, so it drops together with
    // the final beat.
    assign bus.busy = (state == SCAN);

    // Single FSM: direct loads in IDLE, counter-driven beats in SCAN, all
    // outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bus.y     <= '0;
            bus.valid <= 1'b0;
            bus.last  <= 1'b0;
            bus.idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.last <= 1'b0;
                    if (bus.start) begin
                        state     <= SCAN;
                        cnt       <= FIRST_IDX;
                        bus.valid <= 1'b0;
                    end else begin
                        bus.y     <= mux_y;
                        bus.idx   <= bus.s;
                        bus.valid <= (32'(bus.s) < N);
                    end
                end
                SCAN: begin
                    if (bus.en) begin
                        bus.y     <= mux_y;
                        bus.idx   <= cnt;
                        bus.valid <= 1'b1;
                        bus.last  <= (cnt == LAST_IDX);
                        if (cnt == LAST_IDX) begin
                            state <= IDLE;
                        end else begin
`ifdef MUX_SCAN_REVERSE_EN
                            cnt <= cnt - 1'b1;
`else
                            cnt <= cnt + 1'b1;
`endif
                        end
                    end else begin
                        bus.valid <= 1'b0;
                        bus.last  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus.valid <= 1'b0;
                    bus.last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: a 5-word by 8-bit instance checked through an
// expected-beat queue, plus a single-word instance checked directly.
// Honours MUX_SCAN_REVERSE_EN for the expected scan order.
module tb_mux_scan;

    typedef struct packed {
        logic [7:0] y;
        logic [2:0] idx;
        logic       last;
    } exp_t;

    logic clk;
    logic reset;

    int errors = 0;
    int checks = 0;

    exp_t sb[$];

    logic [7:0] words [5];
    int         ord   [5];

    mux_scan_if #(.N(5), .W(8)) bus  ();
    mux_scan_if #(.N(1), .W(8)) bus1 ();

    mux_scan #(.N(5), .W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mux_scan #(.N(1), .W(8)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of main-instance inputs and return just after the edge.
    task automatic applyStimulus(input logic st, input logic e, input logic [2:0] sv);
        bus.start = st;
        bus.en    = e;
        bus.s     = sv;
        @(posedge clk);
        #1;
    endtask

    task automatic pushBeat(input int k, input logic lst);
        exp_t x;
        x.y    = words[k];
        x.idx  = 3'(k);
        x.last = lst;
        sb.push_back(x);
    endtask

    // Monitor: every valid beat on the main instance must match the head of
    // the expected queue.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (bus.valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got y=0x%0h idx=%0d, none expected", bus.y, bus.idx);
                end else begin
                    x = sb.pop_front();
                    checkOutput("beat_y",    32'(bus.y),    32'(x.y));
                    checkOutput("beat_idx",  32'(bus.idx),  32'(x.idx));
                    checkOutput("beat_last", 32'(bus.last), 32'(x.last));
                end
            end
        end
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        words = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef MUX_SCAN_REVERSE_EN
        ord = '{4, 3, 2, 1, 0};
`else
        ord = '{0, 1, 2, 3, 4};
`endif
        bus.d      = {8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
        bus1.d     = 8'hA5;
        bus1.start = 1'b0;
        bus1.en    = 1'b0;
        bus1.s     = 1'b1;

        // Reset held two cycles while start and a select are presented.
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 3'd2);
        applyStimulus(1'b1, 1'b0, 3'd2);
        checkOutput("reset_y",     32'(bus.y),     32'h0);
        checkOutput("reset_valid", 32'(bus.valid), 32'h0);
        checkOutput("reset_busy",  32'(bus.busy),  32'h0);
        checkOutput("reset_last",  32'(bus.last),  32'h0);
        checkOutput("reset_idx",   32'(bus.idx),   32'h0);
        reset = 1'b0;

        // Direct mode: in-range select, then out-of-range select.
        pushBeat(3, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd3);
        checkOutput("direct_valid", 32'(bus.valid), 32'h1);
        applyStimulus(1'b0, 1'b0, 3'd6);
        checkOutput("oor_y",     32'(bus.y),     32'h0);
        checkOutput("oor_valid", 32'(bus.valid), 32'h0);
        checkOutput("oor_idx",   32'(bus.idx),   32'h6);

        // Scan with en held high; select parked out of range.
        applyStimulus(1'b1, 1'b1, 3'd7);
        checkOutput("scan_start_busy",  32'(bus.busy),  32'h1);
        checkOutput("scan_start_valid", 32'(bus.valid), 32'h0);
        for (int i = 0; i < 5; i++) begin
            pushBeat(ord[i], i == 4);
            applyStimulus(1'b0, 1'b1, 3'd7);
            checkOutput("scan_busy", 32'(bus.busy), (i < 4) ? 32'h1 : 32'h0);
        end

        // Back-to-back: start in the cycle last is visible, then stall pattern.
        applyStimulus(1'b1, 1'b1, 3'd7);
        checkOutput("b2b_busy", 32'(bus.busy), 32'h1);
        for (int i = 0; i < 5; i++) begin
            pushBeat(ord[i], i == 4);
            applyStimulus(1'b0, 1'b1, 3'd7);
            if (i < 4) begin
                for (int j = 0; j < 2; j++) begin
                    applyStimulus(1'b0, 1'b0, 3'd7);
                    checkOutput("stall_valid", 32'(bus.valid), 32'h0);
                    checkOutput("stall_y",     32'(bus.y),     32'(words[ord[i]]));
                    checkOutput("stall_idx",   32'(bus.idx),   32'(ord[i]));
                    checkOutput("stall_busy",  32'(bus.busy),  32'h1);
                end
            end
        end
        applyStimulus(1'b0, 1'b0, 3'd7);
        checkOutput("after_stall_scan_busy", 32'(bus.busy), 32'h0);

        // start re-pulsed on the third beat must not restart the scan.
        applyStimulus(1'b1, 1'b0, 3'd7);
        for (int i = 0; i < 5; i++) begin
            pushBeat(ord[i], i == 4);
            applyStimulus(i == 2, 1'b1, 3'd7);
        end
        checkOutput("restart_ignored_busy", 32'(bus.busy), 32'h0);
        applyStimulus(1'b0, 1'b0, 3'd7);
        checkOutput("restart_ignored_idle", 32'(bus.busy), 32'h0);

        // Fresh scan aborted by reset after its third beat.
        applyStimulus(1'b1, 1'b1, 3'd7);
        for (int i = 0; i < 3; i++) begin
            pushBeat(ord[i], 1'b0);
            applyStimulus(1'b0, 1'b1, 3'd7);
        end
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 3'd7);
        checkOutput("abort_busy",  32'(bus.busy),  32'h0);
        checkOutput("abort_valid", 32'(bus.valid), 32'h0);
        checkOutput("abort_y",     32'(bus.y),     32'h0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 3'd7);
        checkOutput("post_abort_busy",  32'(bus.busy),  32'h0);
        checkOutput("post_abort_valid", 32'(bus.valid), 32'h0);

        // Single-word instance: one scan beat is both valid and last.
        bus1.start = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd7);
        bus1.start = 1'b0;
        checkOutput("n1_start_busy", 32'(bus1.busy), 32'h1);
        bus1.en = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd7);
        checkOutput("n1_y",     32'(bus1.y),     32'hA5);
        checkOutput("n1_valid", 32'(bus1.valid), 32'h1);
        checkOutput("n1_last",  32'(bus1.last),  32'h1);
        checkOutput("n1_busy",  32'(bus1.busy),  32'h0);
        bus1.en = 1'b0;
        bus1.s  = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'd7);
        checkOutput("n1_direct_y",     32'(bus1.y),     32'hA5);
        checkOutput("n1_direct_valid", 32'(bus1.valid), 32'h1);
        checkOutput("n1_direct_last",  32'(bus1.last),  32'h0);
        bus1.s = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd7);

        // Every queued beat must have been seen.
        @(negedge clk);
        checkOutput("queue_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
